// File: rtl/muldiv_unit_if.sv
// Request/writeback bundle between the core (master) and the RV32M mul/div unit (slave).
interface muldiv_unit_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  start;
  logic [2:0]            funct3;
  logic [XLEN-1:0]       op_a;
  logic [XLEN-1:0]       op_b;
  logic [REG_ADDR_W-1:0] rd_in;
  logic                  flush;
  logic                  ready;
  logic                  busy;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;

  modport master (
    output start, funct3, op_a, op_b, rd_in, flush,
    input  ready, busy, wb_valid, wb_rd, wb_data
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in, flush,
    output ready, busy, wb_valid, wb_rd, wb_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M mul/div, one bit per cycle; wb_valid XLEN+2 cycles after accept; start ignored while busy, flush aborts.
// MULDIV_EARLY_OUT_EN: div-by-zero, signed overflow and zero-operand multiply bypass CALC (2-cycle latency).
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            fn_q, fn_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       opnd_q, opnd_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic                  neg_a_q, neg_a_d;
  logic                  neg_b_q, neg_b_d;
  logic                  spec_q, spec_d;
  logic [XLEN-1:0]       spec_val_q, spec_val_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]       wb_data_q, wb_data_d;

  // Request decode: signedness, magnitudes and the architecturally fixed special results.
  logic            a_sgn, b_sgn, neg_a_in, neg_b_in;
  logic            div0_in, ovf_in, mz_in, spec_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in, spec_val_in;

  always_comb begin
    a_sgn       = (bus.funct3 == F_MULH) || (bus.funct3 == F_MULHSU) ||
                  (bus.funct3 == F_DIV)  || (bus.funct3 == F_REM);
    b_sgn       = (bus.funct3 == F_MULH) || (bus.funct3 == F_DIV) || (bus.funct3 == F_REM);
    neg_a_in    = a_sgn & bus.op_a[XLEN-1];
    neg_b_in    = b_sgn & bus.op_b[XLEN-1];
    a_mag_in    = neg_a_in ? -bus.op_a : bus.op_a;
    b_mag_in    = neg_b_in ? -bus.op_b : bus.op_b;
    div0_in     = bus.funct3[2] && (bus.op_b == '0);
    ovf_in      = ((bus.funct3 == F_DIV) || (bus.funct3 == F_REM)) &&
                  (bus.op_a == MIN_NEG) && (bus.op_b == '1);
    mz_in       = !bus.funct3[2] && ((bus.op_a == '0) || (bus.op_b == '0));
    spec_in     = div0_in || ovf_in || mz_in;
    spec_val_in = '0;
    if (div0_in) begin
      spec_val_in = bus.funct3[1] ? bus.op_a : '1;
    end else if (ovf_in) begin
      spec_val_in = bus.funct3[1] ? '0 : bus.op_a;
    end
  end

  // Iteration step. acc_q holds {product_hi, multiplier} or {remainder, dividend/quotient}.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
  end

  // Sign correction and result selection.
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result;

  always_comb begin
    prod_fix = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_a_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (fn_q)
      F_MUL:                      result = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:              result = quo_fix;
      default:                    result = rem_fix;
    endcase
    if (spec_q) begin
      result = spec_val_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fn_d       = fn_q;
    rd_d       = rd_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    neg_a_d    = neg_a_q;
    neg_b_d    = neg_b_q;
    spec_d     = spec_q;
    spec_val_d = spec_val_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          fn_d       = bus.funct3;
          rd_d       = bus.rd_in;
          neg_a_d    = neg_a_in;
          neg_b_d    = neg_b_in;
          spec_d     = spec_in;
          spec_val_d = spec_val_in;
          opnd_d     = bus.funct3[2] ? b_mag_in : a_mag_in;
          acc_d      = {{XLEN{1'b0}}, (bus.funct3[2] ? a_mag_in : b_mag_in)};
          cnt_d      = CW'(XLEN - 1);
          state_d    = S_CALC;
`ifdef MULDIV_EARLY_OUT_EN
          if (spec_in) begin
            state_d = S_FIX;
          end
`endif
        end
      end
      S_CALC: begin
        acc_d = fn_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        wb_valid_d = 1'b1;
        wb_data_d  = result;
        wb_rd_d    = rd_q;
        state_d    = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush overrides everything, including a same-cycle start or a pending FIX writeback.
    if (bus.flush) begin
      state_d    = S_IDLE;
      wb_valid_d = 1'b0;
      wb_data_d  = wb_data_q;
      wb_rd_d    = wb_rd_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      fn_q       <= '0;
      rd_q       <= '0;
      opnd_q     <= '0;
      acc_q      <= '0;
      neg_a_q    <= 1'b0;
      neg_b_q    <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fn_q       <= fn_d;
      rd_q       <= rd_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      neg_a_q    <= neg_a_d;
      neg_b_q    <= neg_b_d;
      spec_q     <= spec_d;
      spec_val_q <= spec_val_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
    end
  end

  assign bus.ready    = (state_q == S_IDLE);
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;

endmodule
